// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//   Shares the register file's single write port between two writeback
//   sources. Port 0 (ALU/execute) has priority over port 1 (load return);
//   a starvation guard force-grants port 1 after MAX_WAIT consecutive lost
//   cycles. The register file write is presented one cycle after the
//   handshake, from registered outputs.
//
//   Optional feature macro: REG_WRITE_ARB_RR_EN
//     defined   -> contended cycles alternate round-robin (1-bit pointer),
//                  no starve counter, o_starved tied 0.
//     undefined -> fixed priority with starvation guard.
//
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_valid0/i_rd0/i_data0           port 0 write request (high priority)
//   o_ready0                         port 0 accepted this cycle (comb)
//   i_valid1/i_rd1/i_data1           port 1 write request (low priority)
//   o_ready1                         port 1 accepted this cycle (comb)
//   o_reg_write                      register file write enable (reg)
//   o_write_rd / o_write_data        register file destination / data (reg)
//   o_starved                        port 1 grant this cycle was forced (comb)
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid0,
    input  logic [ADDR_W-1:0] i_rd0,
    input  logic [DATA_W-1:0] i_data0,
    output logic              o_ready0,
    input  logic              i_valid1,
    input  logic [ADDR_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_ready1,
    output logic              o_reg_write,
    output logic [ADDR_W-1:0] o_write_rd,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_starved
);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("reg_write_arbiter: MAX_WAIT must be in 1..15");
    end

    logic    grant0_c;
    logic    grant1_c;
    logic    starved_c;
    wr_req_t req0_c;
    wr_req_t req1_c;
    wr_req_t sel_c;

    assign req0_c = {i_rd0, i_data0};
    assign req1_c = {i_rd1, i_data1};

`ifdef REG_WRITE_ARB_RR_EN
    // Round-robin pointer: names the port that wins the next contended cycle.
    logic rr_ptr_q;
    logic rr_ptr_d;

    // Grant selection; only contended grants advance the pointer.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (i_valid0 && i_valid1) begin
            grant0_c = ~rr_ptr_q;
            grant1_c = rr_ptr_q;
            rr_ptr_d = ~rr_ptr_q;
        end else begin
            grant0_c = i_valid0;
            grant1_c = i_valid1;
        end
    end

    assign starved_c = 1'b0;

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    localparam int unsigned     CNT_W      = 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    // Consecutive cycles port 1 has been waiting without a grant.
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Fixed-priority grant with starvation override; counter saturates.
    always_comb begin
        grant0_c  = 1'b0;
        grant1_c  = 1'b0;
        starved_c = 1'b0;
        starve_d  = '0;
        if (i_valid0 && i_valid1) begin
            if (starve_q == WAIT_LIMIT) begin
                grant1_c  = 1'b1;
                starved_c = 1'b1;
            end else begin
                grant0_c  = 1'b1;
            end
        end else begin
            grant0_c = i_valid0;
            grant1_c = i_valid1;
        end
        if (i_valid1 && !grant1_c) begin
            starve_d = (starve_q == WAIT_LIMIT) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Readies depend only on valids and arbiter state, never on o_reg_write.
    assign o_ready0  = grant0_c;
    assign o_ready1  = grant1_c;
    assign o_starved = starved_c;

    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rd_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Write-port next state: capture the granted payload; x0 is never enabled.
    always_comb begin
        sel_c  = grant1_c ? req1_c : req0_c;
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (grant0_c || grant1_c) begin
            we_d   = (sel_c.rd != '0);
            rd_d   = sel_c.rd;
            data_d = sel_c.data;
        end
    end

    // Write-port registers; reset drops any write not yet presented.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign o_reg_write  = we_q;
    assign o_write_rd   = rd_q;
    assign o_write_data = data_q;

endmodule
